// File: rtl/sbox_arbiter.sv
// sbox_arbiter
// Shares one iterative SubBytes engine between the cipher round datapath
// (port 0) and the key-expansion unit (port 1). Grants one request at a time
// with round-robin tie-breaking. Drives the engine start/done handshake and
// returns the result to the owner. A watchdog answers with an error response
// if the engine does not finish within TIMEOUT cycles.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   req_i         per-requester request level
//   data0_i/1_i   requester states, captured on the grant edge
//   gnt_o         one-hot one-cycle grant pulse
//   resp_valid_o  one-hot one-cycle response pulse to the owner
//   resp_data_o   result, held until the next response
//   resp_err_o    pulses with resp_valid_o on a timeout response
//   busy_o        high while waiting on the engine
//   eng_start_o   one-cycle engine start pulse
//   eng_s_o       engine input state, held from grant to next grant
//   eng_s_i       engine result
//   eng_done_i    engine done pulse
//
// State | meaning
// IDLE  | no request owned; grants the next winner
// WAIT  | engine running for owner; waits for done or watchdog expiry

module sbox_arbiter #(
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       resp_valid_o,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             resp_err_o,
    output logic             busy_o,
    output logic             eng_start_o,
    output logic [WIDTH-1:0] eng_s_o,
    input  logic [WIDTH-1:0] eng_s_i,
    input  logic             eng_done_i
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t         state, state_nxt;
    logic           owner, owner_nxt;
    logic           last, last_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           win;
    logic           timeout_hit;

    logic [1:0]       gnt_nxt;
    logic [1:0]       rv_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic             err_nxt;
    logic             start_nxt;
    logic [WIDTH-1:0] es_nxt;

    // A lone requester wins outright; on a tie the port not served last wins.
    always_comb begin
        case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~last;
        endcase
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign busy_o      = (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_i != 2'b00) state_nxt = WAIT;
            WAIT: if (eng_done_i || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; pulses default low every cycle.
    always_comb begin
        gnt_nxt   = 2'b00;
        rv_nxt    = 2'b00;
        err_nxt   = 1'b0;
        start_nxt = 1'b0;
        rdata_nxt = resp_data_o;
        es_nxt    = eng_s_o;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_nxt   = win ? 2'b10 : 2'b01;
                    start_nxt = 1'b1;
                    es_nxt    = win ? data1_i : data0_i;
                    owner_nxt = win;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                // done takes priority over a watchdog expiring on the same edge
                if (eng_done_i) begin
                    rdata_nxt = eng_s_i;
                    rv_nxt    = owner ? 2'b10 : 2'b01;
                    last_nxt  = owner;
                end else if (timeout_hit) begin
                    rdata_nxt = '0;
                    rv_nxt    = owner ? 2'b10 : 2'b01;
                    err_nxt   = 1'b1;
                    last_nxt  = owner;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_o        <= 2'b00;
            resp_valid_o <= 2'b00;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b0;
            eng_start_o  <= 1'b0;
            eng_s_o      <= '0;
            owner        <= 1'b0;
            last         <= 1'b1;
            cnt          <= '0;
        end else begin
            gnt_o        <= gnt_nxt;
            resp_valid_o <= rv_nxt;
            resp_data_o  <= rdata_nxt;
            resp_err_o   <= err_nxt;
            eng_start_o  <= start_nxt;
            eng_s_o      <= es_nxt;
            owner        <= owner_nxt;
            last         <= last_nxt;
            cnt          <= cnt_nxt;
        end
    end

endmodule

// File: doc/sbox_arbiter.md
# sbox_arbiter

Shares one iterative SubBytes engine between two requesters: the cipher round datapath (port 0) and the key-expansion unit (port 1). Each requester hands over a full WIDTH-bit state. The arbiter grants one request at a time, fairly, and drives the engine's start/done handshake. It returns the substituted result to the owning requester, and a watchdog guarantees that every granted request gets a response.

## Interface
Parameters:
- WIDTH, 128, width of the state processed by the engine; multiple of 8.
- TIMEOUT, 32, number of WAIT cycles before a grant is abandoned; must be ≥ 20 with the 16-byte iterative engine.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  2  per-requester request level.
- data0_i  in  WIDTH  requester 0 state; sampled only on the grant edge.
- data1_i  in  WIDTH  requester 1 state; sampled only on the grant edge.
- gnt_o  out  2  one-hot, one-cycle grant pulse.
- resp_valid_o  out  2  one-hot, one-cycle response pulse to the owner.
- resp_data_o  out  WIDTH  result, valid while resp_valid_o ≠ 0 and held until the next response.
- resp_err_o  out  1  high together with resp_valid_o when the response is a timeout.
- busy_o  out  1  high while in WAIT.
- eng_start_o  out  1  one-cycle start pulse to the engine.
- eng_s_o  out  WIDTH  engine input state, held from the grant until the next grant.
- eng_s_i  in  WIDTH  engine result.
- eng_done_i  in  1  engine done pulse.

## Operation
- Two states: IDLE and WAIT. Internal registers: owner (1 bit), last (1 bit), cnt (5 bits, sized for TIMEOUT).
- IDLE with req_i ≠ 0:
  - Pick the winner. A single requester wins alone. If both request, the winner is the port ≠ last.
  - On that edge: gnt_o[w] ← 1, eng_start_o ← 1, eng_s_o ← selected data, owner ← w, cnt ← 0, state ← WAIT.
- IDLE with req_i = 0: no change. All pulse outputs return to 0.
- WAIT, every edge: gnt_o ← 0, eng_start_o ← 0.
- WAIT with eng_done_i = 1:
  - resp_data_o ← eng_s_i, resp_valid_o[owner] ← 1, resp_err_o ← 0.
  - last ← owner, state ← IDLE.
- WAIT with eng_done_i = 0 and cnt = TIMEOUT−1:
  - resp_data_o ← 0, resp_valid_o[owner] ← 1, resp_err_o ← 1.
  - last ← owner, state ← IDLE.
- WAIT otherwise: cnt ← cnt+1.
- eng_done_i arriving in IDLE is ignored.
- Requester rule: hold req_i[k] high until gnt_o[k] is seen, then drop it within the cycle after the grant. A request still high when the arbiter re-enters IDLE counts as a new request.
- Data inputs may change freely after the grant, because they are captured on the grant edge.
- Reset, including mid-operation:
  - state ← IDLE, last ← 1, so port 0 wins the first tie.
  - All outputs ← 0, including eng_s_o and resp_data_o.
  - The engine is reset in the same cycle by the system, so no stale done can arrive later.

## Timing
- Grant edge E0: gnt_o and eng_start_o are both high during the cycle after E0.
- The engine samples start at E1, iterates over E2..E17 and raises done at E18.
- The arbiter registers the response at E19. gnt_o → resp_valid_o latency is therefore 19 cycles.
- The earliest next grant is the edge after the response (E20). Throughput is 1 state per 20 cycles.
- Timeout response: resp_valid_o at edge E_TIMEOUT, i.e. TIMEOUT cycles after the grant.
- Round-robin: with both requesters continuously requesting, grants alternate 0,1,0,1…
- eng_done_i and the timeout in the same edge: done wins and the response is not an error.

## Test plan
- After reset, req_i=01 with data0_i = all bytes 0x53 (real engine, forward table) -> gnt_o=01 the cycle after the request, eng_start_o one pulse, resp_valid_o=01 exactly 19 cycles after the grant, resp_data_o = all bytes 0xED, resp_err_o=0.
- req_i=11 held continuously, data0_i=0, data1_i = all 0x01 -> first grant to port 0 (response all 0x63), second to port 1 (response all 0x7C), then strict alternation for 6 grants with no idle gap beyond 1 cycle.
- Engine replaced by a model that never asserts done, req_i=10 -> resp_valid_o=10, resp_err_o=1, resp_data_o=0 exactly TIMEOUT (32) cycles after the grant; the next request is then granted normally.
- Change data0_i to a different value on the cycle after gnt_o -> eng_s_o and the result still reflect the value captured on the grant edge.
- Assert rst at cycle 10 of a WAIT -> all outputs 0 and busy_o=0 on the following edge; a new req_i=01 issued after reset completes in 19 cycles with no spurious response from the aborted request.
- Inject a spurious eng_done_i pulse while in IDLE -> no resp_valid_o and no state change.
